valid_ready_packer: RTL and testbench
=====================================

VALID_READY_PACKER -- requirements
Module: valid_ready_packer

Parameters
REQ-001 The block SHALL have parameter W, default 8, giving the output word width in bits (W >= 2).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock on which all logic is rising-edge triggered.
REQ-003 The block SHALL have port reset, input, 1 bit, the reset, synchronous and active-high.
REQ-004 The block SHALL have port down_data, input, 1 bit, the serial data bit offered by the upstream valid/ready slice.
REQ-005 The block SHALL have port down_valid, input, 1 bit, which qualifies down_data.
REQ-006 The block SHALL have port down_last, input, 1 bit, which marks the offered bit as the final bit of a packet; it is qualified by down_valid.
REQ-007 The block SHALL have port down_ready, output, 1 bit, which SHALL be high when this block accepts the offered bit.
REQ-008 The block SHALL have port up_data, output, W bits, the packed word.
REQ-009 The block SHALL have port up_valid, output, 1 bit, which qualifies up_data, up_count and up_last.
REQ-010 The block SHALL have port up_count, output, $clog2(W+1) bits, the number of meaningful bits in up_data (1..W).
REQ-011 The block SHALL have port up_last, output, 1 bit, which marks the word that ends a packet.
REQ-012 The block SHALL have port up_ready, input, 1 bit, the downstream consumer's ready signal.

Function
REQ-013 A down-side transfer SHALL occur when down_valid & down_ready are both high at a rising edge of clk; an up-side transfer SHALL occur when up_valid & up_ready are both high at a rising edge of clk.
REQ-014 down_ready SHALL equal up_ready | ~up_valid and SHALL have no combinational dependence on down_valid, down_data or down_last.
REQ-015 Accepted bits SHALL be packed LSB-first: the k-th accepted bit of a word (k = 0..W-1) SHALL land in accumulator bit k.
REQ-016 An internal counter cnt (0..W-1) SHALL count the bits held in the accumulator.
REQ-017 A word SHALL complete on an accepted bit when cnt == W-1 or down_last == 1.
REQ-018 On a completing transfer, the output register SHALL load the accumulator including the current bit.
REQ-019 On that load, bits above position cnt SHALL be zero, up_count SHALL be cnt+1, and up_last SHALL equal down_last.
REQ-020 On that load, up_valid SHALL be set and cnt SHALL return to 0.
REQ-021 Latency SHALL be one cycle: the word SHALL be visible on up_* in the cycle after the completing down-side transfer.
REQ-022 On a non-completing transfer, the block SHALL store the bit and increment cnt, leaving up_* unchanged.
REQ-023 An up-side transfer SHALL clear up_valid unless a completing down-side transfer occurs in the same cycle, in which case the new word SHALL load and up_valid SHALL stay high (load beats clear).
REQ-024 up_data, up_count and up_last SHALL remain stable while up_valid & ~up_ready.
REQ-025 With up_ready held high, the block SHALL sustain one accepted bit per cycle with no bubbles at word boundaries.
REQ-026 While up_valid & ~up_ready, down_ready SHALL be low, so no bit is dropped or overwritten, including a partially filled accumulator.
REQ-027 down_last asserted with cnt == W-1 SHALL produce up_count = W and up_last = 1.

Reset
REQ-028 When reset is high at a rising edge of clk, cnt SHALL be 0 and the accumulator SHALL be 0.
REQ-029 When reset is high at a rising edge of clk, up_valid, up_last and up_data SHALL be 0 and up_count SHALL be 0.
REQ-030 Reset SHALL take priority over any simultaneous transfer.
REQ-031 A partially filled word SHALL be discarded by reset, and the next accepted bit SHALL become bit 0 of a fresh word.
REQ-032 down_ready SHALL be high in the first cycle after reset.

Structure
REQ-033 A shared package vr_pkg SHALL hold the default width constant PACK_W = 8 and the count-width function/localparam used for up_count.
REQ-034 The block SHALL be a single module containing the accumulator, cnt and the output register, with no sub-module.

Verification (W = 8)
REQ-035 Stimulus: bits 1,0,1,1,0,0,1,0 with up_ready = 1 and down_last = 0. Required response: one cycle after the 8th transfer, up_data = 8'h4D, up_count = 8, up_last = 0, up_valid high for exactly one cycle.
REQ-036 Stimulus: bits 1,1,1 with down_last on the 3rd bit. Required response: up_data = 8'h07, up_count = 3, up_last = 1, and the next word starts at bit 0.
REQ-037 Stimulus: 32 random bits streamed with up_ready = 1. Required response: 4 words matching the LSB-first reference packing, down_ready never low, 32 bits accepted in 32 cycles.
REQ-038 Stimulus: up_ready = 0 after word 1 is produced, with 20 more bits offered. Required response: down_ready = 0 after word 1 is produced, up_* stable; on raising up_ready the words drain in order with no loss or duplication.
REQ-039 Stimulus: assert reset after 5 accepted bits, then feed 8'hA5 LSB-first. Required response: the output word equals 8'hA5 with up_count = 8, and no remnant of the discarded bits appears.
REQ-040 Stimulus: up_ready = 1 and a completing transfer in the same cycle as an up-side transfer. Required response: up_valid stays high and the new word appears the next cycle.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared constants for the valid/ready bit packer: default word width and
// the width of the per-word bit count.
package vr_pkg;

   localparam int PACK_W = 8;

   // Bits needed to hold a count in the range 0..w.
   function automatic int count_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/valid_ready_packer.sv
// Serial-to-parallel packer: accepts one bit per valid/ready transfer, packs
// LSB-first into W-bit words, and emits a word on a full word or packet end.
module valid_ready_packer
   import vr_pkg::*;
#(
   parameter int W = PACK_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        down_data,
   input  logic                        down_valid,
   input  logic                        down_last,
   output logic                        down_ready,
   output logic [W-1:0]                up_data,
   output logic                        up_valid,
   output logic [count_width(W)-1:0]   up_count,
   output logic                        up_last,
   input  logic                        up_ready
);

   localparam int CW = count_width(W);

   logic [W-1:0]  acc_r;
   logic [CW-1:0] cnt_r;
   logic          accept_s;
   logic          complete_s;
   logic [W-1:0]  word_s;

   // Upstream may advance whenever the output slot is free or being drained.
   assign down_ready = up_ready | ~up_valid;

   // Transfer qualification and the word as it stands including the offered bit.
   always_comb begin
      accept_s   = down_valid & down_ready;
      complete_s = 1'b0;
      word_s     = {W{1'b0}};
      if (accept_s) begin
         complete_s = (cnt_r == CW'(W - 1)) | down_last;
      end else begin
         complete_s = 1'b0;
      end
      // Bits above the current position stay zero so short words are clean.
      for (int i = 0; i < W; i++) begin
         if (CW'(i) < cnt_r) begin
            word_s[i] = acc_r[i];
         end else if (CW'(i) == cnt_r) begin
            word_s[i] = down_data;
         end else begin
            word_s[i] = 1'b0;
         end
      end
   end

   // Accumulator and bit counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r <= {W{1'b0}};
         cnt_r <= {CW{1'b0}};
      end else if (complete_s) begin
         acc_r <= {W{1'b0}};
         cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
         acc_r <= word_s;
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Output word register; loading a new word wins over the downstream clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         up_data  <= {W{1'b0}};
         up_count <= {CW{1'b0}};
         up_last  <= 1'b0;
         up_valid <= 1'b0;
      end else if (complete_s) begin
         up_data  <= word_s;
         up_count <= cnt_r + CW'(1);
         up_last  <= down_last;
         up_valid <= 1'b1;
      end else if (up_valid & up_ready) begin
         up_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_valid_ready_packer.sv
// Self-checking bench for valid_ready_packer: directed vector table, stall,
// reset and randomized traffic against a queue-based packing model.
module tb_valid_ready_packer;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          down_data;
   logic          down_valid;
   logic          down_last;
   logic          down_ready;
   logic [W-1:0]  up_data;
   logic          up_valid;
   logic [CW-1:0] up_count;
   logic          up_last;
   logic          up_ready;

   always #5 clk = ~clk;

   valid_ready_packer #(.W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .down_data  (down_data),
      .down_valid (down_valid),
      .down_last  (down_last),
      .down_ready (down_ready),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_count   (up_count),
      .up_last    (up_last),
      .up_ready   (up_ready)
   );

   typedef struct {
      logic [W-1:0] data;
      int           count;
      bit           last;
   } word_t;

   typedef struct {
      bit           dv;
      bit           dd;
      bit           dl;
      bit           ur;
      bit           ev;
      logic [W-1:0] ed;
      int           ec;
      bit           el;
   } vec_t;

   int    total = 0;
   int    bad   = 0;
   int    accepted = 0;
   int    consumed = 0;
   word_t exp_q[$];
   bit    cur_bits[$];
   vec_t  tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock: drive inputs, check against the model, advance the model at the edge.
   task automatic cycle(input bit rst, input bit dv, input bit dd, input bit dl, input bit ur);
      word_t w;
      word_t h;
      bit    m_valid;
      bit    m_ready;
      reset = rst; down_valid = dv; down_data = dd; down_last = dl; up_ready = ur;
      #2;
      if (rst) begin
         exp_q.delete();
         cur_bits.delete();
      end else begin
         m_valid = (exp_q.size() != 0);
         m_ready = ur | !m_valid;
         check("down_ready_rule", down_ready, m_ready);
         check("up_valid_model", up_valid, m_valid);
         if (m_valid && ur) begin
            h = exp_q.pop_front();
            check("word_data", up_data, h.data);
            check("word_count", up_count, h.count);
            check("word_last", up_last, h.last);
            consumed++;
         end
         if (dv && m_ready) begin
            accepted++;
            cur_bits.push_back(dd);
            if (cur_bits.size() == W || dl) begin
               w.data = '0;
               foreach (cur_bits[k]) w.data[k] = cur_bits[k];
               w.count = cur_bits.size();
               w.last  = dl;
               exp_q.push_back(w);
               cur_bits.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit           rbits[32];
      bit           sbits[20];
      logic [W-1:0] snap_d;
      logic [CW-1:0] snap_c;
      logic         snap_l;
      int           c0;
      int           a0;
      int           low;
      logic [W-1:0] a5;

      // bits 1,0,1,1,0,0,1,0 -> 8'h4D, then 1,1,1(last) -> 8'h07, then 1(last) with same-cycle drain
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4D, 8, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 3, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0};

      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      reset = 1'b0; up_ready = 1'b0; down_valid = 1'b0;
      #1;
      check("rst_up_valid", up_valid, 1'b0);
      check("rst_up_data", up_data, 8'h00);
      check("rst_up_count", up_count, 0);
      check("rst_up_last", up_last, 1'b0);
      check("rst_down_ready", down_ready, 1'b1);

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         cycle(1'b0, tbl[i].dv, tbl[i].dd, tbl[i].dl, tbl[i].ur);
         check("tbl_valid", up_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            check("tbl_data", up_data, tbl[i].ed);
            check("tbl_count", up_count, tbl[i].ec);
            check("tbl_last", up_last, tbl[i].el);
         end
      end

      // 32 random bits streamed with the consumer always ready
      c0 = consumed; a0 = accepted; low = 0;
      foreach (rbits[i]) rbits[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 1'b1, rbits[i], 1'b0, 1'b1);
         if (!down_ready) low++;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("stream_ready_low", low, 0);
      check("stream_accepted", accepted - a0, 32);
      check("stream_words", consumed - c0, 4);

      // Stall after word 1 with 20 more bits offered, then drain
      c0 = consumed;
      foreach (sbits[i]) sbits[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      snap_d = up_data; snap_c = up_count; snap_l = up_last;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, sbits[0], 1'b0, 1'b0);
         check("stall_valid", up_valid, 1'b1);
         check("stall_ready", down_ready, 1'b0);
         check("stall_data", up_data, snap_d);
         check("stall_count", up_count, snap_c);
         check("stall_last", up_last, snap_l);
      end
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, sbits[i], (i == 19), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("drain_words", consumed - c0, 4);
      check("drain_empty", exp_q.size(), 0);

      // Reset discards a partial word
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("mid_rst_valid", up_valid, 1'b0);
      check("mid_rst_data", up_data, 8'h00);
      a5 = 8'hA5;
      for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, a5[i], 1'b0, 1'b1);
      check("a5_valid", up_valid, 1'b1);
      check("a5_data", up_data, 8'hA5);
      check("a5_count", up_count, 8);
      check("a5_last", up_last, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized mixed traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("final_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
